ifetch_wb: RTL and testbench
============================

// Module: ifetch_wb
// PURPOSE
//  Instruction-fetch master on the Wishbone classic bus, upstream of the core RAM slave.
//  Fetches sequential 32-bit words from a PC into a small prefetch FIFO and presents them to decode.
//  Handles branch redirects with a flush, retries on RTY and reports bus faults.
//  Read-only master: it drives WE low and CTI_O as classic (3'b000) at all times.
// PARAMETERS
//  FIFO_DEPTH  2         prefetch entries (power of 2, >=2)
//  RESET_PC    32'h0     fetch address after reset
//  RTY_MAX     4         consecutive RTY terminations before the word is reported as a fault
// PORTS
//  clk          in   1   clock, all logic on rising edge
//  rst_n        in   1   asynchronous active-low reset
//  CYC          out  1   Wishbone cycle
//  STB          out  1   Wishbone strobe
//  ADR          out  32  word address, ADR[1:0]=0
//  DAT_I        in   32  read data from slave
//  WE           out  1   constant 0
//  CTI_O        out  3   constant 3'b000
//  ACK/ERR/RTY  in   1   slave terminations (one port each)
//  redirect     in   1   branch/jump: flush and refetch from redirect_pc
//  redirect_pc  in   32  new fetch PC
//  instr_valid  out  1   FIFO head valid
//  instr_ready  in   1   decode accepts head (pop when valid&ready)
//  instr        out  32  head instruction word
//  instr_pc     out  32  PC of head word
//  instr_fault  out  1   head is a fault marker (instr=0)
// BEHAVIOUR
//  Reset: CYC=STB=0, ADR=RESET_PC, instr_valid=0, instr_fault=0, instr=0, instr_pc=0, FIFO empty,
//  retry count 0, discard flag 0, state IDLE.
//  States: IDLE -> REQ when (FIFO count + 0) < FIFO_DEPTH and not halted; CYC=STB=1, ADR=fetch_pc.
//  REQ: hold CYC/STB/ADR stable until ACK|ERR|RTY sampled high.
//   ACK: push {DAT_I, ADR, fault=0}, fetch_pc+=4 (wraps mod 2^32), retry count=0.
//   ERR: push {0, ADR, fault=1}, go HALT.
//   RTY: retry count+1; if it reaches RTY_MAX push fault entry and go HALT, else reissue same ADR.
//   After termination, next request may start the same edge if a FIFO slot remains, else IDLE.
//   Against the 1-cycle RAM slave this gives one word every 2 cycles.
//  HALT: no requests; only redirect leaves HALT.
//  Credit: request issued only if FIFO count (after this cycle's pop) < FIFO_DEPTH; never overflows.
//  Simultaneous push and pop when full or empty both allowed; count unchanged.
//  redirect: FIFO flushed, fetch_pc=redirect_pc, retry count=0, HALT cleared, same edge.
//   If a request is outstanding it is NOT aborted: CYC/STB held until termination.
//   discard flag set; that termination is dropped (no push, ERR/RTY ignored).
//   The new request is then issued.
//   redirect with valid&ready in same cycle: flush wins, pop ignored.
//   redirect same cycle as ACK: that data is discarded.
//  instr_* are FIFO head outputs (registered storage), zero when empty.
//  Reset asserted mid-transfer: CYC/STB drop immediately (async), all state returns to reset values.
// CONFIGURATION
//  IFETCH_ALIGN_CHECK_EN defined:
//   redirect_pc[1:0]!=0 pushes a fault entry with instr_pc=redirect_pc, no bus access, goes HALT.
//  IFETCH_ALIGN_CHECK_EN undefined:
//   redirect_pc[1:0] ignored (treated as 0); no alignment fault ever raised.
// TESTING
//  1. Reset, RESET_PC=0, RAM words 0..3 = 11,22,33,44, ready=1 -> instr 11,22,33,44 with pc 0,4,8,C.
//  2. ready=0 for 20 cycles -> exactly FIFO_DEPTH reads issued, CYC low afterwards.
//     ready=1 -> order intact, no lost words.
//  3. redirect to 0x40 while REQ at 0x8 outstanding -> ACK for 0x8 dropped, next instr_pc=0x40.
//  4. Slave answers ERR at 0x10 -> fault entry pc=0x10, no further CYC until redirect.
//     Redirect to 0 -> fetching resumes.
//  5. Slave gives RTY 3x then ACK (RTY_MAX=4) -> normal word; RTY 4x -> fault entry, HALT.
//  6. With IFETCH_ALIGN_CHECK_EN: redirect to 0x42 -> fault pc=0x42, CYC stays 0.
//     Without: fetch from 0x40.

Source files
------------

// File: rtl/ifetch_wb_if.sv
// Wishbone classic read-side bundle between the instruction-fetch master and the memory slave.
// Signal names follow the Wishbone port names used by the fetch unit.
interface ifetch_wb_if;
    logic        CYC;
    logic        STB;
    logic [31:0] ADR;
    logic [31:0] DAT_I;
    logic        WE;
    logic [2:0]  CTI_O;
    logic        ACK;
    logic        ERR;
    logic        RTY;

    modport master (
        output CYC, STB, ADR, WE, CTI_O,
        input  DAT_I, ACK, ERR, RTY
    );

    modport slave (
        input  CYC, STB, ADR, WE, CTI_O,
        output DAT_I, ACK, ERR, RTY
    );
endinterface

// File: rtl/ifetch_wb.sv
// Wishbone classic instruction-fetch master: sequential prefetch into a small FIFO, redirect flush,
// RTY retry and fault entries. Define IFETCH_ALIGN_CHECK_EN to trap misaligned redirect targets.
module ifetch_wb #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [31:0] RESET_PC   = 32'h0,
    parameter int unsigned RTY_MAX    = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    ifetch_wb_if.master  wb,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic [31:0]  instr,
    output logic [31:0]  instr_pc,
    output logic         instr_fault
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned RW = $clog2(RTY_MAX + 1);

    typedef enum logic [1:0] {IDLE, REQ, HALT} state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } entry_t;

    state_e        state_q, state_d;
    logic          cyc_q, cyc_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          discard_q, discard_d;
    logic          halt_pend_q, halt_pend_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    entry_t        mem_q [FIFO_DEPTH];
    entry_t        mem_d [FIFO_DEPTH];

    logic          term;
    logic          busy;
    logic          flush;
    logic          push;
    logic          pop;
    logic          start;
    logic          go_halt;
    logic          misaligned;
    logic [31:0]   target_pc;
    entry_t        push_entry;
    entry_t        head;

    assign wb.CYC   = cyc_q;
    assign wb.STB   = cyc_q;
    assign wb.ADR   = adr_q;
    assign wb.WE    = 1'b0;
    assign wb.CTI_O = 3'b000;

    assign head        = mem_q[rd_ptr_q];
    assign instr_valid = (count_q != '0);
    assign instr       = instr_valid ? head.instr : 32'h0;
    assign instr_pc    = instr_valid ? head.pc    : 32'h0;
    assign instr_fault = instr_valid & head.fault;

    assign target_pc = redirect_pc & 32'hFFFF_FFFC;
`ifdef IFETCH_ALIGN_CHECK_EN
    assign misaligned = (redirect_pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign term = cyc_q & (wb.ACK | wb.ERR | wb.RTY);
    // An open request survives a redirect; its termination is swallowed via the discard flag.
    assign busy = cyc_q & ~term;
    assign pop  = instr_valid & instr_ready & ~redirect;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d     = state_q;
        cyc_d       = cyc_q;
        adr_d       = adr_q;
        fetch_pc_d  = fetch_pc_q;
        retry_d     = retry_q;
        discard_d   = discard_q;
        halt_pend_d = halt_pend_q;
        flush       = 1'b0;
        push        = 1'b0;
        push_entry  = '0;
        start       = 1'b0;
        go_halt     = 1'b0;

        if (redirect) begin
            flush       = 1'b1;
            retry_d     = '0;
            halt_pend_d = 1'b0;
            fetch_pc_d  = target_pc;
            discard_d   = busy;
            if (misaligned) begin
                push             = 1'b1;
                push_entry.pc    = redirect_pc;
                push_entry.fault = 1'b1;
                if (busy) halt_pend_d = 1'b1;
                else      go_halt     = 1'b1;
            end else if (!busy) begin
                start = 1'b1;
            end
        end else begin
            unique case (state_q)
                IDLE: start = 1'b1;
                REQ: begin
                    if (term) begin
                        if (discard_q) begin
                            discard_d = 1'b0;
                            if (halt_pend_q) go_halt = 1'b1;
                            else             start   = 1'b1;
                        end else if (wb.ACK) begin
                            push             = 1'b1;
                            push_entry.instr = wb.DAT_I;
                            push_entry.pc    = adr_q;
                            fetch_pc_d       = adr_q + 32'd4;
                            retry_d          = '0;
                            start            = 1'b1;
                        end else if (wb.ERR || (retry_q == RW'(RTY_MAX - 1))) begin
                            push             = 1'b1;
                            push_entry.pc    = adr_q;
                            push_entry.fault = 1'b1;
                            retry_d          = '0;
                            go_halt          = 1'b1;
                        end else begin
                            retry_d = retry_q + RW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end

        // FIFO bookkeeping: a redirect clears it before any same-cycle fault entry lands.
        mem_d    = mem_q;
        wr_ptr_d = flush ? '0 : wr_ptr_q;
        rd_ptr_d = flush ? '0 : rd_ptr_q;
        count_d  = flush ? '0 : count_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            count_d  = count_d - CW'(1);
        end
        if (push) begin
            mem_d[wr_ptr_d] = push_entry;
            wr_ptr_d        = wr_ptr_d + PW'(1);
            count_d         = count_d + CW'(1);
        end

        // Credit check uses the post-pop, post-push occupancy so the FIFO can never overflow.
        if (go_halt) begin
            state_d     = HALT;
            cyc_d       = 1'b0;
            halt_pend_d = 1'b0;
        end else if (start) begin
            if (count_d < CW'(FIFO_DEPTH)) begin
                state_d = REQ;
                cyc_d   = 1'b1;
                adr_d   = fetch_pc_d;
            end else begin
                state_d = IDLE;
                cyc_d   = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cyc_q       <= 1'b0;
            adr_q       <= RESET_PC;
            fetch_pc_q  <= RESET_PC;
            retry_q     <= '0;
            discard_q   <= 1'b0;
            halt_pend_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            adr_q       <= adr_d;
            fetch_pc_q  <= fetch_pc_d;
            retry_q     <= retry_d;
            discard_q   <= discard_d;
            halt_pend_q <= halt_pend_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // NOTE: payload storage is not reset; count_q gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_ifetch_wb.sv
// Self-checking bench for ifetch_wb: 1-cycle Wishbone RAM slave with ERR/RTY injection,
// and a scoreboard queue of expected fetch entries compared on every decode pop.
module tb_ifetch_wb;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_ready = 1'b0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_fault;

    logic        err_en = 1'b0;
    logic [31:0] err_addr = 32'hFFFF_FFF0;
    logic [31:0] rty_addr = 32'hFFFF_FFF0;
    int          rty_limit = 0;
    int          rty_cnt;

    int checks = 0;
    int errors = 0;
    int ack_cnt = 0;
    int cyc_cnt = 0;
    int rty_seen = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    ifetch_wb_if wb();

    ifetch_wb #(.FIFO_DEPTH(DEPTH), .RESET_PC(32'h0), .RTY_MAX(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wb          (wb),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_fault (instr_fault)
    );

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h11;
            32'h4:   return 32'h22;
            32'h8:   return 32'h33;
            32'hC:   return 32'h44;
            default: return 32'hA000_0000 | a;
        endcase
    endfunction

    // Single-wait-state RAM slave: answers one cycle after STB, then stays quiet for a cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb.ACK   <= 1'b0;
            wb.ERR   <= 1'b0;
            wb.RTY   <= 1'b0;
            wb.DAT_I <= 32'h0;
            rty_cnt  <= 0;
        end else begin
            wb.ACK <= 1'b0;
            wb.ERR <= 1'b0;
            wb.RTY <= 1'b0;
            if (wb.CYC && wb.STB && !(wb.ACK || wb.ERR || wb.RTY)) begin
                if (err_en && wb.ADR == err_addr) begin
                    wb.ERR <= 1'b1;
                end else if (wb.ADR == rty_addr && rty_cnt < rty_limit) begin
                    wb.RTY  <= 1'b1;
                    rty_cnt <= rty_cnt + 1;
                end else begin
                    wb.ACK   <= 1'b1;
                    wb.DAT_I <= ram_word(wb.ADR);
                    if (wb.ADR == rty_addr) rty_cnt <= 0;
                end
            end
        end
    end

    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (wb.CYC) cyc_cnt++;
        if (wb.CYC && wb.ACK) ack_cnt++;
        if (wb.CYC && wb.RTY) rty_seen++;
        if (rst_n && instr_valid && instr_ready && !redirect) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: got pc=%h instr=%h fault=%b, expected no entry", instr_pc, instr, instr_fault);
            end else begin
                e = exp_q.pop_front();
                if (instr !== e.instr || instr_pc !== e.pc || instr_fault !== e.fault) begin
                    errors++;
                    $display("FAIL sb_head: got pc=%h instr=%h fault=%b, expected pc=%h instr=%h fault=%b",
                             instr_pc, instr, instr_fault, e.pc, e.instr, e.fault);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [31:0] pc);
        exp_t e;
        e.instr = ram_word(pc);
        e.pc    = pc;
        e.fault = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic expect_fault(input logic [31:0] pc);
        exp_t e;
        e.instr = 32'h0;
        e.pc    = pc;
        e.fault = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        instr_ready = 1'b1;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        instr_ready = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d entries pending after %0d cycles, required 0", name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        exp_q.delete();
        tick();
        redirect = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n       = 1'b0;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        exp_q.delete();
        tick();
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (wb.CYC !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %b, required 0", wb.CYC); end
        checks++; if (wb.STB !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b, required 0", wb.STB); end
        checks++; if (wb.ADR !== 32'h0) begin errors++; $display("FAIL reset_adr: got %h, required 0", wb.ADR); end
        checks++; if (wb.WE !== 1'b0) begin errors++; $display("FAIL reset_we: got %b, required 0", wb.WE); end
        checks++; if (wb.CTI_O !== 3'b000) begin errors++; $display("FAIL reset_cti: got %b, required 000", wb.CTI_O); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", instr_valid); end
        checks++;
        if (instr !== 32'h0 || instr_pc !== 32'h0 || instr_fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_head: got instr=%h pc=%h fault=%b, required all 0", instr, instr_pc, instr_fault);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fetch();
        expect_word(32'h0);
        expect_word(32'h4);
        expect_word(32'h8);
        expect_word(32'hC);
        drain("fetch", 100);
    endtask

    task automatic test_backpressure();
        apply_reset();
        rst_n   = 1'b1;
        ack_cnt = 0;
        repeat (20) tick();
        checks++; if (ack_cnt !== DEPTH) begin errors++; $display("FAIL bp_reads: got %0d, required %0d", ack_cnt, DEPTH); end
        checks++; if (wb.CYC !== 1'b0) begin errors++; $display("FAIL bp_cyc_idle: got %b, required 0", wb.CYC); end
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b, required 1", instr_valid); end
        for (int i = 0; i < 8; i++) expect_word(32'(i * 4));
        drain("bp", 100);
    endtask

    task automatic test_redirect();
        apply_reset();
        rst_n = 1'b1;
        repeat (10) tick();
        checks++; if (wb.CYC !== 1'b0) begin errors++; $display("FAIL rd_full_cyc: got %b, required 0", wb.CYC); end
        expect_word(32'h0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        checks++;
        if (wb.CYC !== 1'b1 || wb.ADR !== 32'h8) begin
            errors++;
            $display("FAIL rd_req8: got cyc=%b adr=%h, required cyc=1 adr=00000008", wb.CYC, wb.ADR);
        end
        redirect_to(32'h40);
        checks++;
        if (instr_valid !== 1'b0 || wb.CYC !== 1'b1 || wb.ADR !== 32'h8) begin
            errors++;
            $display("FAIL rd_hold: got valid=%b cyc=%b adr=%h, required valid=0 cyc=1 adr=00000008", instr_valid, wb.CYC, wb.ADR);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b0 || wb.CYC !== 1'b1 || wb.ADR !== 32'h40) begin
            errors++;
            $display("FAIL rd_drop: got valid=%b cyc=%b adr=%h, required valid=0 cyc=1 adr=00000040", instr_valid, wb.CYC, wb.ADR);
        end
        expect_word(32'h40);
        expect_word(32'h44);
        expect_word(32'h48);
        drain("redirect", 100);
    endtask

    task automatic test_err();
        err_en   = 1'b1;
        err_addr = 32'h10;
        redirect_to(32'h0);
        expect_word(32'h0);
        expect_word(32'h4);
        expect_word(32'h8);
        expect_word(32'hC);
        expect_fault(32'h10);
        drain("err", 200);
        cyc_cnt = 0;
        repeat (20) tick();
        checks++; if (cyc_cnt !== 0) begin errors++; $display("FAIL err_halt_cyc: got %0d bus cycles, required 0", cyc_cnt); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL err_halt_valid: got %b, required 0", instr_valid); end
        err_en = 1'b0;
        redirect_to(32'h0);
        expect_word(32'h0);
        expect_word(32'h4);
        drain("err_resume", 100);
    endtask

    task automatic test_retry();
        rty_addr  = 32'h8;
        rty_limit = 3;
        redirect_to(32'h0);
        rty_seen = 0;
        expect_word(32'h0);
        expect_word(32'h4);
        expect_word(32'h8);
        expect_word(32'hC);
        drain("rty3", 200);
        checks++; if (rty_seen !== 3) begin errors++; $display("FAIL rty3_count: got %0d, required 3", rty_seen); end
        rty_limit = 4;
        redirect_to(32'h0);
        rty_seen = 0;
        expect_word(32'h0);
        expect_word(32'h4);
        expect_fault(32'h8);
        drain("rty4", 200);
        checks++; if (rty_seen !== 4) begin errors++; $display("FAIL rty4_count: got %0d, required 4", rty_seen); end
        cyc_cnt = 0;
        repeat (20) tick();
        checks++; if (cyc_cnt !== 0) begin errors++; $display("FAIL rty4_halt_cyc: got %0d bus cycles, required 0", cyc_cnt); end
        rty_limit = 0;
        rty_addr  = 32'hFFFF_FFF0;
    endtask

    task automatic test_align();
        cyc_cnt = 0;
        redirect_to(32'h42);
`ifdef IFETCH_ALIGN_CHECK_EN
        expect_fault(32'h42);
        drain("align", 50);
        repeat (10) tick();
        checks++; if (cyc_cnt !== 0) begin errors++; $display("FAIL align_cyc: got %0d bus cycles, required 0", cyc_cnt); end
`else
        checks++;
        if (wb.CYC !== 1'b1 || wb.ADR !== 32'h40) begin
            errors++;
            $display("FAIL align_adr: got cyc=%b adr=%h, required cyc=1 adr=00000040", wb.CYC, wb.ADR);
        end
        expect_word(32'h40);
        expect_word(32'h44);
        drain("align", 100);
`endif
    endtask

    task automatic test_reset_mid();
        redirect_to(32'h20);
        checks++; if (wb.CYC !== 1'b1) begin errors++; $display("FAIL mid_pre_cyc: got %b, required 1", wb.CYC); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (wb.CYC !== 1'b0 || wb.STB !== 1'b0 || wb.ADR !== 32'h0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got cyc=%b stb=%b adr=%h valid=%b, required 0/0/00000000/0",
                     wb.CYC, wb.STB, wb.ADR, instr_valid);
        end
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        expect_word(32'h0);
        expect_word(32'h4);
        expect_word(32'h8);
        drain("mid_recover", 100);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_backpressure();
        test_redirect();
        test_err();
        test_retry();
        test_align();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
